// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU trigger controller: handshake modes and FSM state encoding.
package tlu_pkg;

  localparam logic [1:0] TLU_MODE_NOHS   = 2'd0;
  localparam logic [1:0] TLU_MODE_SIMPLE = 2'd1;
  localparam logic [1:0] TLU_MODE_DATA   = 2'd2;
  localparam logic [1:0] TLU_MODE_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } tlu_state_t;

  // The reserved mode behaves exactly like the simple busy handshake.
  function automatic logic [1:0] tlu_norm_mode(input logic [1:0] mode);
    return (mode == TLU_MODE_RSVD) ? TLU_MODE_SIMPLE : mode;
  endfunction

endpackage

// File: rtl/tlu_sync.sv
// Multi-flop synchroniser for the asynchronous TRIGGER line plus a registered rising-edge detector.
module tlu_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_SYS,
  input  logic din,
  output logic trig_s,
  output logic trig_rise
);

  logic [SYNC_STAGES-1:0] sync_q;

  // trig_s and trig_rise come from the same clock edge so the FSM sees them aligned.
  always_ff @(posedge CLK or posedge RST_SYS) begin
    if (RST_SYS) begin
      sync_q    <= '0;
      trig_s    <= 1'b0;
      trig_rise <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
      trig_s    <= sync_q[SYNC_STAGES-1];
      trig_rise <= sync_q[SYNC_STAGES-1] & ~trig_s;
    end
  end

endmodule

// File: rtl/tlu_trigger_ctrl.sv
// TLU handshake controller: no-handshake, busy handshake or trigger-number readout,
// producing one event word per accepted trigger on a valid/ready output.
module tlu_trigger_ctrl
  import tlu_pkg::*;
#(
  parameter int TRIG_NUM_W  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CLK_HALF    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  CLK,
  input  logic                  RST_SYS,
  input  logic                  ENABLE,
  input  logic [1:0]            MODE,
  input  logic                  TRIGGER,
  input  logic                  DUT_BUSY,
  output logic                  BUSY,
  output logic                  TRIGGER_CLOCK,
  output logic                  EVT_VALID,
  input  logic                  EVT_READY,
  output logic [TRIG_NUM_W-1:0] EVT_NUM,
  output logic                  EVT_SKIP,
  output logic                  EVT_TIMEOUT,
  output logic [TRIG_NUM_W-1:0] LOCAL_CNT,
  output logic [1:0]            STATE_DBG
);

  localparam int PH_W  = $clog2(2 * CLK_HALF);
  localparam int BIT_W = $clog2(TRIG_NUM_W);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_HALF - 1);
  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLK_HALF);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TRIG_NUM_W - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  tlu_state_t            state;
  logic [1:0]            mode_q;
  logic [PH_W-1:0]       ph_q;
  logic [BIT_W-1:0]      bit_q;
  logic [TO_W-1:0]       to_q;
  logic [TRIG_NUM_W-2:0] sr_q;
  logic [TRIG_NUM_W-1:0] last_num;
  logic                  seen_first;
  logic                  hs_done;

  logic                  trig_s;
  logic                  trig_rise;
  logic                  fire;
  logic [PH_W-1:0]       ph_next;
  logic [TRIG_NUM_W-1:0] shift_next;
  logic [TRIG_NUM_W-1:0] cnt_inc;
  logic                  skip_d;
  logic [1:0]            mode_in;

  tlu_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK       (CLK),
    .RST_SYS   (RST_SYS),
    .din       (TRIGGER),
    .trig_s    (trig_s),
    .trig_rise (trig_rise)
  );

  // Event handshake: a word transfers on any rising CLK edge with EVT_VALID && EVT_READY
  // both high; EVT_VALID never drops before that, and the word is stable while it waits.
  assign fire       = EVT_VALID & EVT_READY;
  assign ph_next    = ph_q + PH_W'(1);
  assign shift_next = {trig_s, sr_q};
  assign cnt_inc    = LOCAL_CNT + TRIG_NUM_W'(1);
  assign skip_d     = seen_first && (shift_next != (last_num + TRIG_NUM_W'(1)));
  assign mode_in    = tlu_norm_mode(MODE);
  assign STATE_DBG  = state;

  always_ff @(posedge CLK or posedge RST_SYS) begin
    if (RST_SYS) begin
      state         <= ST_IDLE;
      mode_q        <= TLU_MODE_NOHS;
      ph_q          <= '0;
      bit_q         <= '0;
      to_q          <= '0;
      sr_q          <= '0;
      last_num      <= '0;
      seen_first    <= 1'b0;
      hs_done       <= 1'b0;
      BUSY          <= 1'b0;
      TRIGGER_CLOCK <= 1'b0;
      EVT_VALID     <= 1'b0;
      EVT_NUM       <= '0;
      EVT_SKIP      <= 1'b0;
      EVT_TIMEOUT   <= 1'b0;
      LOCAL_CNT     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          BUSY          <= 1'b0;
          TRIGGER_CLOCK <= 1'b0;
          hs_done       <= 1'b0;
          if (ENABLE && trig_rise) begin
            mode_q    <= mode_in;
            LOCAL_CNT <= cnt_inc;
            ph_q      <= '0;
            bit_q     <= '0;
            to_q      <= '0;
            case (mode_in)
              TLU_MODE_NOHS: begin
                state       <= ST_HOLD;
                EVT_VALID   <= 1'b1;
                EVT_NUM     <= cnt_inc;
                EVT_SKIP    <= 1'b0;
                EVT_TIMEOUT <= 1'b0;
              end
              TLU_MODE_DATA: begin
                state         <= ST_SHIFT;
                BUSY          <= 1'b1;
                TRIGGER_CLOCK <= 1'b1;
              end
              default: begin
                state <= ST_ACK;
                BUSY  <= 1'b1;
              end
            endcase
          end
        end

        ST_ACK: begin
          BUSY <= 1'b1;
          if (!trig_s || (to_q == TO_LAST)) begin
            state       <= ST_HOLD;
            EVT_VALID   <= 1'b1;
            EVT_NUM     <= LOCAL_CNT;
            EVT_SKIP    <= 1'b0;
            EVT_TIMEOUT <= trig_s;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end

        // Each trigger-clock period is CLK_HALF cycles high then CLK_HALF low; the data
        // bit is taken on the last low cycle, when the TLU's answer has crossed the synchroniser.
        ST_SHIFT: begin
          BUSY <= 1'b1;
          if (ph_q == PH_LAST) begin
            ph_q <= '0;
            if (bit_q == BIT_LAST) begin
              state         <= ST_HOLD;
              TRIGGER_CLOCK <= 1'b0;
              EVT_VALID     <= 1'b1;
              EVT_NUM       <= shift_next;
              EVT_SKIP      <= skip_d;
              EVT_TIMEOUT   <= 1'b0;
              last_num      <= shift_next;
              seen_first    <= 1'b1;
            end else begin
              sr_q          <= shift_next[TRIG_NUM_W-1:1];
              bit_q         <= bit_q + BIT_W'(1);
              TRIGGER_CLOCK <= 1'b1;
            end
          end else begin
            ph_q          <= ph_next;
            TRIGGER_CLOCK <= (ph_next < PH_HIGH);
          end
        end

        ST_HOLD: begin
          BUSY <= (mode_q != TLU_MODE_NOHS);
          if (fire) begin
            EVT_VALID <= 1'b0;
            hs_done   <= 1'b1;
          end
          // BUSY deliberately stays high in the first IDLE cycle and drops one cycle later.
          if ((fire || hs_done) && !DUT_BUSY) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlu_trigger_ctrl.sv
// Directed bench for tlu_trigger_ctrl: a TLU model drives TRIGGER, expected event words
// are queued as each trigger is issued and popped when the controller hands them out.
module tb_tlu_trigger_ctrl;
  import tlu_pkg::*;

  localparam int W   = 16;
  localparam int SS  = 2;
  localparam int CH  = 4;
  localparam int TO  = 1024;

  logic         CLK;
  logic         RST_SYS;
  logic         ENABLE;
  logic [1:0]   MODE;
  logic         TRIGGER;
  logic         DUT_BUSY;
  logic         BUSY;
  logic         TRIGGER_CLOCK;
  logic         EVT_VALID;
  logic         EVT_READY;
  logic [W-1:0] EVT_NUM;
  logic         EVT_SKIP;
  logic         EVT_TIMEOUT;
  logic [W-1:0] LOCAL_CNT;
  logic [1:0]   STATE_DBG;

  // expected word = {timeout, skip, num}
  logic [W+1:0] exp_q[$];
  int           n_asserts = 0;
  int           n_fail    = 0;
  logic [W-1:0] tb_cnt;
  logic [W-1:0] tb_last;
  logic         tb_seen;

  tlu_trigger_ctrl #(
    .TRIG_NUM_W  (W),
    .SYNC_STAGES (SS),
    .CLK_HALF    (CH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK           (CLK),
    .RST_SYS       (RST_SYS),
    .ENABLE        (ENABLE),
    .MODE          (MODE),
    .TRIGGER       (TRIGGER),
    .DUT_BUSY      (DUT_BUSY),
    .BUSY          (BUSY),
    .TRIGGER_CLOCK (TRIGGER_CLOCK),
    .EVT_VALID     (EVT_VALID),
    .EVT_READY     (EVT_READY),
    .EVT_NUM       (EVT_NUM),
    .EVT_SKIP      (EVT_SKIP),
    .EVT_TIMEOUT   (EVT_TIMEOUT),
    .LOCAL_CNT     (LOCAL_CNT),
    .STATE_DBG     (STATE_DBG)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST_SYS   = 1'b1;
    TRIGGER   = 1'b0;
    EVT_READY = 1'b0;
    DUT_BUSY  = 1'b0;
    repeat (3) @(negedge CLK);
    RST_SYS = 1'b0;
    tb_cnt  = '0;
    tb_last = '0;
    tb_seen = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  // scoreboard: sample away from both edges so same-negedge driver writes have settled
  always @(negedge CLK) begin
    logic [W+1:0] exp_w;
    #2;
    if (!RST_SYS && EVT_VALID && EVT_READY) begin
      check("evt_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("evt_num", 32'(EVT_NUM), 32'(exp_w[W-1:0]));
        check("evt_skip", 32'(EVT_SKIP), 32'(exp_w[W]));
        check("evt_timeout", 32'(EVT_TIMEOUT), 32'(exp_w[W+1]));
      end
    end
  end

  // TLU model for trigger-data mode; abort_bit >= 0 pulses reset inside that bit period.
  task automatic run_mode2(input logic [W-1:0] num, input int abort_bit);
    int   e, e_busy, e_valid, pulses, hi_run, lo_run;
    logic prev_tclk;
    logic width_ok;
    logic aborted;
    logic exp_skip;
    exp_skip = tb_seen && (num != tb_last + W'(1));
    tb_cnt   = tb_cnt + W'(1);
    if (abort_bit < 0) begin
      exp_q.push_back({1'b0, exp_skip, num});
      tb_seen = 1'b1;
      tb_last = num;
    end
    MODE = TLU_MODE_DATA;
    ENABLE = 1'b1;
    EVT_READY = 1'b0;
    @(negedge CLK);
    TRIGGER = 1'b1;
    e = -1; e_busy = -1; e_valid = -1; pulses = 0; hi_run = 0; lo_run = 0;
    prev_tclk = 1'b0; width_ok = 1'b1; aborted = 1'b0;
    while (e_valid < 0 && e < 600 && !aborted) begin
      @(posedge CLK);
      e++;
      @(negedge CLK);
      if (BUSY && e_busy < 0) e_busy = e;
      if (EVT_VALID) e_valid = e;
      if (TRIGGER_CLOCK) begin
        if (!prev_tclk) begin
          if (pulses > 0 && lo_run != CH) width_ok = 1'b0;
          if (pulses < W) TRIGGER = num[pulses];
          pulses++;
          hi_run = 0;
        end
        hi_run++;
        if (abort_bit >= 0 && pulses == abort_bit + 1 && hi_run == 2) aborted = 1'b1;
      end else begin
        if (prev_tclk) begin
          if (hi_run != CH) width_ok = 1'b0;
          lo_run = 0;
        end
        lo_run++;
      end
      prev_tclk = TRIGGER_CLOCK;
    end
    if (aborted) begin
      RST_SYS = 1'b1;
      TRIGGER = 1'b0;
      #1;
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_tclk", 32'(TRIGGER_CLOCK), 32'd0);
      check("rst_valid", 32'(EVT_VALID), 32'd0);
      check("rst_num", 32'(EVT_NUM), 32'd0);
      check("rst_skip", 32'(EVT_SKIP), 32'd0);
      check("rst_timeout", 32'(EVT_TIMEOUT), 32'd0);
      check("rst_local_cnt", 32'(LOCAL_CNT), 32'd0);
      check("rst_state", 32'(STATE_DBG), 32'(ST_IDLE));
      @(negedge CLK);
      RST_SYS = 1'b0;
      tb_cnt  = '0;
      tb_last = '0;
      tb_seen = 1'b0;
      repeat (4) @(negedge CLK);
    end else begin
      TRIGGER = 1'b0;
      check("m2_valid_seen", 32'(e_valid >= 0), 32'd1);
      check("m2_busy_latency", 32'(e_busy), 32'(SS + 1));
      check("m2_shift_cycles", 32'(e_valid - e_busy), 32'(2 * CH * W));
      check("m2_pulses", 32'(pulses), 32'(W));
      check("m2_pulse_width", 32'(width_ok), 32'd1);
      check("m2_local_cnt", 32'(LOCAL_CNT), 32'(tb_cnt));
    end
  endtask

  task automatic run_mode1(input logic [1:0] mode_val, input logic hold_high);
    int e, e_busy, e_valid;
    tb_cnt = tb_cnt + W'(1);
    exp_q.push_back({hold_high, 1'b0, tb_cnt});
    MODE = mode_val;
    ENABLE = 1'b1;
    EVT_READY = 1'b0;
    @(negedge CLK);
    TRIGGER = 1'b1;
    e = -1; e_busy = -1; e_valid = -1;
    while (e_valid < 0 && e < TO + 100) begin
      @(posedge CLK);
      e++;
      @(negedge CLK);
      if (BUSY && e_busy < 0) begin
        e_busy = e;
        if (!hold_high) TRIGGER = 1'b0;
      end
      if (EVT_VALID) e_valid = e;
    end
    check("m1_valid_seen", 32'(e_valid >= 0), 32'd1);
    check("m1_busy_latency", 32'(e_busy), 32'(SS + 1));
    if (hold_high) check("m1_timeout_cycles", 32'(e_valid - e_busy), 32'(TO));
    check("m1_local_cnt", 32'(LOCAL_CNT), 32'(tb_cnt));
  endtask

  // Called at the negedge where EVT_VALID was first seen high.
  task automatic finish_event(input int ready_delay, input int dbusy_cycles, input logic exp_busy);
    if (ready_delay > 0) begin
      repeat (ready_delay) @(negedge CLK);
      check("busy_wait_ready", 32'(BUSY), 32'(exp_busy));
      check("valid_wait_ready", 32'(EVT_VALID), 32'd1);
    end
    EVT_READY = 1'b1;
    @(negedge CLK);
    EVT_READY = 1'b0;
    check("valid_after_xfer", 32'(EVT_VALID), 32'd0);
    if (dbusy_cycles > 0) begin
      repeat (dbusy_cycles) @(negedge CLK);
      check("busy_dut_busy", 32'(BUSY), 32'd1);
      check("state_dut_busy", 32'(STATE_DBG), 32'(ST_HOLD));
      DUT_BUSY = 1'b0;
    end
    repeat (2) @(negedge CLK);
    check("busy_released", 32'(BUSY), 32'(1'b0));
    check("state_released", 32'(STATE_DBG), 32'(ST_IDLE));
  endtask

  initial begin
    logic busy_seen;
    ENABLE    = 1'b1;
    MODE      = TLU_MODE_NOHS;
    TRIGGER   = 1'b0;
    DUT_BUSY  = 1'b0;
    EVT_READY = 1'b0;
    RST_SYS   = 1'b1;
    repeat (3) @(negedge CLK);
    RST_SYS = 1'b0;
    @(negedge CLK);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_tclk", 32'(TRIGGER_CLOCK), 32'd0);
    check("reset_valid", 32'(EVT_VALID), 32'd0);
    check("reset_num", 32'(EVT_NUM), 32'd0);
    check("reset_skip", 32'(EVT_SKIP), 32'd0);
    check("reset_timeout", 32'(EVT_TIMEOUT), 32'd0);
    check("reset_local_cnt", 32'(LOCAL_CNT), 32'd0);
    check("reset_state", 32'(STATE_DBG), 32'(ST_IDLE));
    tb_cnt = '0; tb_last = '0; tb_seen = 1'b0;

    // trigger-data readout of 0x1234, BUSY held while the word waits
    run_mode2(16'h1234, -1);
    finish_event(6, 0, 1'b1);

    // consecutive numbers 5, 6, 8 after a fresh reset
    do_reset();
    run_mode2(16'd5, -1);
    finish_event(0, 0, 1'b1);
    run_mode2(16'd6, -1);
    finish_event(0, 0, 1'b1);
    run_mode2(16'd8, -1);
    finish_event(2, 0, 1'b1);
    check("seq_local_cnt", 32'(LOCAL_CNT), 32'(tb_cnt));

    // busy handshake: normal release, timeout, and reserved mode with DUT_BUSY hold
    do_reset();
    run_mode1(TLU_MODE_SIMPLE, 1'b0);
    finish_event(3, 0, 1'b1);
    repeat (4) @(negedge CLK);
    run_mode1(TLU_MODE_SIMPLE, 1'b1);
    finish_event(8, 0, 1'b1);
    TRIGGER = 1'b0;
    repeat (5) @(negedge CLK);
    DUT_BUSY = 1'b1;
    run_mode1(TLU_MODE_RSVD, 1'b0);
    finish_event(0, 6, 1'b1);
    repeat (4) @(negedge CLK);

    // no-handshake mode: BUSY never asserted, local numbers 1..3
    do_reset();
    MODE = TLU_MODE_NOHS;
    EVT_READY = 1'b1;
    busy_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tb_cnt = tb_cnt + W'(1);
      exp_q.push_back({1'b0, 1'b0, tb_cnt});
      TRIGGER = 1'b1;
      repeat (6) begin
        @(negedge CLK);
        busy_seen = busy_seen | BUSY;
      end
      TRIGGER = 1'b0;
      repeat ($urandom_range(6, 10)) begin
        @(negedge CLK);
        busy_seen = busy_seen | BUSY;
      end
    end
    EVT_READY = 1'b0;
    check("m0_busy_never", 32'(busy_seen), 32'd0);
    check("m0_local_cnt", 32'(LOCAL_CNT), 32'(tb_cnt));

    // ENABLE low: trigger ignored
    ENABLE = 1'b0;
    TRIGGER = 1'b1;
    repeat (10) @(negedge CLK);
    TRIGGER = 1'b0;
    repeat (6) @(negedge CLK);
    ENABLE = 1'b1;
    check("disabled_local_cnt", 32'(LOCAL_CNT), 32'(tb_cnt));
    check("disabled_state", 32'(STATE_DBG), 32'(ST_IDLE));

    // reset during bit 7 of a readout; next readout is complete and not flagged as a skip
    do_reset();
    run_mode2(16'h00AA, -1);
    finish_event(0, 0, 1'b1);
    repeat (3) @(negedge CLK);
    run_mode2(16'h5555, 7);
    run_mode2(16'h1234, -1);
    finish_event(0, 0, 1'b1);

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/tlu_trigger_ctrl.md
# tlu_trigger_ctrl

Parametrised TLU (Trigger Logic Unit) handshake controller. It replaces the fixed 16-bit, single-mode handshake with a selectable mode: no-handshake, simple busy handshake, or trigger-data handshake. It adds a configurable trigger-number width, a glitch-free registered trigger clock, a DUT-busy hold, a handshake timeout, a trigger-skip check and a valid/ready event output. It sits between the LVDS pad buffers (IBUFDS/OBUFDS, kept at top level) and the event builder.

## Interface
- TRIG_NUM_W, 16: trigger-number width, 8..32.
- SYNC_STAGES, 2: synchroniser depth on TRIGGER, ≥2.
- CLK_HALF, 4: CLK cycles per trigger-clock half period; must be ≥ SYNC_STAGES+1.
- TIMEOUT_CYC, 1024: mode-1 handshake timeout in CLK cycles.

Ports:
- CLK  in  1  single system clock; all logic on posedge.
- RST_SYS  in  1  asynchronous, active-high reset.
- ENABLE  in  1  accept new triggers only when 1; sampled in IDLE only.
- MODE  in  2  0 = no handshake, 1 = simple handshake, 2 = trigger-data, 3 = reserved (treated as 1); latched on leaving IDLE.
- TRIGGER  in  1  trigger/data line from pad buffer, asynchronous to CLK.
- DUT_BUSY  in  1  downstream readout busy; extends BUSY.
- BUSY  out  1  busy to TLU, registered.
- TRIGGER_CLOCK  out  1  trigger clock to TLU, registered (never gated CLK).
- EVT_VALID  out  1  event word valid.
- EVT_READY  in  1  event word accepted when EVT_VALID && EVT_READY.
- EVT_NUM  out  TRIG_NUM_W  received (mode 2) or local (modes 0/1) trigger number.
- EVT_SKIP  out  1  mode 2: EVT_NUM ≠ previous+1.
- EVT_TIMEOUT  out  1  mode 1: handshake timed out.
- LOCAL_CNT  out  TRIG_NUM_W  accepted-trigger counter.

## Operation
- TRIGGER passes through a SYNC_STAGES flop chain, followed by a rising-edge detector (trig_s, trig_rise).
- States: IDLE, ACK, SHIFT, HOLD.
- IDLE: BUSY=0, TRIGGER_CLOCK=0. If ENABLE && trig_rise: latch MODE, LOCAL_CNT += 1 (wraps to 0 at 2^TRIG_NUM_W). Then mode 0 → HOLD; mode 1/3 → ACK; mode 2 → SHIFT. Otherwise stay.
- ACK: BUSY=1, timeout counter runs. On trig_s==0 → HOLD. On counter reaching TIMEOUT_CYC-1 → HOLD with timeout flag set.
- SHIFT: BUSY=1.
  - TRIG_NUM_W trigger-clock periods, each CLK_HALF cycles high then CLK_HALF cycles low.
  - Bit i (LSB first) = trig_s on the last low-phase cycle of period i.
  - After bit TRIG_NUM_W-1 → HOLD.
- HOLD: event register loaded on entry, EVT_VALID=1.
  - EVT_NUM = shifted value (mode 2) or new LOCAL_CNT (modes 0/1).
  - EVT_SKIP = (mode 2) && seen_first && (value ≠ last_num+1, modulo 2^TRIG_NUM_W); last_num is updated and seen_first is set on every mode-2 event.
  - EVT_TIMEOUT = timeout flag.
  - Exit to IDLE when the handshake has fired (this or an earlier cycle of HOLD) and DUT_BUSY==0 in the same cycle or later.
  - BUSY=1 throughout HOLD in modes 1/2; BUSY=0 always in mode 0.
- Mode 0 with EVT_VALID still pending: no new trigger is accepted until HOLD exits; triggers arriving meanwhile are lost. This is the required behaviour for mode 0.
- ENABLE dropping mid-sequence has no effect until IDLE.
- Event outputs hold their value while EVT_VALID=0 after a transfer; they are don't-care for checking.

## Timing
- Reset values: state IDLE, BUSY=0, TRIGGER_CLOCK=0, EVT_VALID=0, EVT_NUM=0, EVT_SKIP=0, EVT_TIMEOUT=0, LOCAL_CNT=0, seen_first=0, synchronisers 0.
- Reset asserted mid-SHIFT or mid-HOLD aborts immediately; any pending event is discarded.
- Let cycle 0 be the first posedge sampling TRIGGER=1 into stage 1. Then:
  - trig_rise is seen at cycle SYNC_STAGES.
  - BUSY=1 and the state change are visible at cycle SYNC_STAGES+1.
- Mode 2: the first TRIGGER_CLOCK rising edge is in the first SHIFT cycle. SHIFT lasts exactly 2·CLK_HALF·TRIG_NUM_W cycles. EVT_VALID rises the cycle after SHIFT ends.
- Mode 1 timeout: EVT_TIMEOUT=1 exactly TIMEOUT_CYC cycles after entering ACK if TRIGGER stays high.
- BUSY falls in the cycle after IDLE is re-entered. Minimum IDLE dwell is 1 cycle.

## Structure
- Package tlu_pkg: mode constants (TLU_MODE_NOHS, TLU_MODE_SIMPLE, TLU_MODE_DATA) and the state encoding.
- Sub-module tlu_sync: parametrised synchroniser plus rising-edge detector, instantiated once for TRIGGER.
- Pad buffers stay outside this block.

## Test plan
- Mode 2, TRIG_NUM_W=16, CLK_HALF=4, TLU model drives 0x1234 LSB-first → EVT_NUM=0x1234, EVT_SKIP=0, exactly 16 TRIGGER_CLOCK pulses of 4 high/4 low, BUSY held until EVT_READY.
- Mode 2, consecutive numbers 5, 6, 8 → EVT_SKIP = 0, 0, 1; LOCAL_CNT = 3.
- Mode 1, TRIGGER held high forever, TIMEOUT_CYC=1024 → EVT_TIMEOUT=1 at ACK+1024; BUSY drops after EVT_READY.
- Mode 0, 3 triggers with EVT_READY=1 → BUSY never 1, EVT_NUM = 1, 2, 3.
- DUT_BUSY=1 during HOLD, EVT_READY pulsed → BUSY stays 1 until DUT_BUSY falls, then 0 next cycle.
- RST_SYS pulsed during bit 7 of SHIFT → all outputs at reset values in the same cycle; the next trigger produces a full 16-pulse sequence with EVT_SKIP=0.
